// File: rtl/vending_ctrl_multi.sv
// Multi-product coin vending controller: credit, purchase, refund and greedy change FSM.
// Latency: coin/purchase/cancel take effect on the next edge; listo is combinational.
// Backpressure: change coins stall on cambio_ready low. Optional SALES_COUNT_EN adds a ventas counter.
module vending_ctrl_multi #(
    parameter int NUM_PROD   = 4,
    parameter int CREDIT_W   = 6,
    parameter int MAX_CREDIT = 31
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   moneda,
    input  logic [NUM_PROD-1:0]          comprar,
    input  logic                         cancelar,
    input  logic [NUM_PROD*CREDIT_W-1:0] precios,
    input  logic                         cambio_ready,
    output logic [NUM_PROD-1:0]          listo,
    output logic [NUM_PROD-1:0]          vend,
    output logic [CREDIT_W-1:0]          total,
    output logic                         cambio_valid,
    output logic [1:0]                   cambio_coin,
    output logic                         coin_reject
`ifdef SALES_COUNT_EN
    ,
    output logic [15:0]                  ventas
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_t;

    localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   total_q, total_d;
    logic [NUM_PROD-1:0]   vend_q, vend_d;
    logic                  cambio_valid_q, cambio_valid_d;
    logic [1:0]            cambio_coin_q, cambio_coin_d;
    logic                  coin_reject_q, coin_reject_d;

    logic [NUM_PROD-1:0]   buy_oh;
    logic [CREDIT_W-1:0]   buy_price;
    logic [CREDIT_W:0]     coin_sum;
    logic                  coin_in, coin_fits, cancel_ok, buy_ok, coin_ok, change_take;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] c);
        case (c)
            2'b01:   coin_value = CREDIT_W'(1);
            2'b10:   coin_value = CREDIT_W'(2);
            2'b11:   coin_value = CREDIT_W'(5);
            default: coin_value = '0;
        endcase
    endfunction

    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] t);
        if (t >= CREDIT_W'(5))      greedy_coin = 2'b11;
        else if (t >= CREDIT_W'(2)) greedy_coin = 2'b10;
        else if (t != '0)           greedy_coin = 2'b01;
        else                        greedy_coin = 2'b00;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_PROD; i++) begin
            listo[i] = (state_q == S_IDLE)
                     && (total_q >= precios[i*CREDIT_W +: CREDIT_W])
                     && (precios[i*CREDIT_W +: CREDIT_W] != '0);
        end
    end

    // Only the lowest requested product is considered; a higher one never substitutes.
    assign buy_oh = comprar & (~comprar + NUM_PROD'(1));

    always_comb begin
        buy_price = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (buy_oh[i]) buy_price = buy_price | precios[i*CREDIT_W +: CREDIT_W];
        end
    end

    assign coin_in     = (moneda != 2'b00);
    assign coin_sum    = {1'b0, total_q} + {1'b0, coin_value(moneda)};
    assign coin_fits   = (coin_sum <= MAX_C);
    assign cancel_ok   = (state_q == S_IDLE) && cancelar && (total_q != '0);
    assign buy_ok      = !cancel_ok && ((buy_oh & listo) != '0);
    assign coin_ok     = (state_q == S_IDLE) && coin_in && !cancel_ok && !buy_ok && coin_fits;
    assign change_take = (state_q == S_CHANGE) && cambio_valid_q && cambio_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            total_q        <= '0;
            vend_q         <= '0;
            cambio_valid_q <= 1'b0;
            cambio_coin_q  <= 2'b00;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            total_q        <= total_d;
            vend_q         <= vend_d;
            cambio_valid_q <= cambio_valid_d;
            cambio_coin_q  <= cambio_coin_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        case (state_q)
            S_IDLE: begin
                if (cancel_ok) begin
                    state_d = S_CHANGE;
                end else if (buy_ok) begin
                    state_d = S_VEND;
                    total_d = total_q - buy_price;
                end else if (coin_ok) begin
                    total_d = coin_sum[CREDIT_W-1:0];
                end
            end
            S_VEND: begin
                state_d = (total_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                if (change_take) begin
                    total_d = total_q - coin_value(cambio_coin_q);
                    if (total_d == '0) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered Moore outputs are precomputed from the next state and credit.
    always_comb begin
        vend_d         = buy_ok ? buy_oh : '0;
        cambio_valid_d = (state_d == S_CHANGE);
        cambio_coin_d  = cambio_valid_d ? greedy_coin(total_d) : 2'b00;
        coin_reject_d  = coin_in && !coin_ok;
    end

    assign vend         = vend_q;
    assign total        = total_q;
    assign cambio_valid = cambio_valid_q;
    assign cambio_coin  = cambio_coin_q;
    assign coin_reject  = coin_reject_q;

`ifdef SALES_COUNT_EN
    logic [15:0] ventas_q, ventas_d;

    always_comb begin
        ventas_d = ventas_q;
        if (buy_ok && ventas_q != 16'hFFFF) ventas_d = ventas_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ventas_q <= '0;
        else        ventas_q <= ventas_d;
    end

    assign ventas = ventas_q;
`endif

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Scoreboard bench for vending_ctrl_multi: a credit/pending-coin-list reference model feeds
// expectation queues that a negedge monitor drains as the DUT presents its outputs.
module tb_vending_ctrl_multi;
    localparam int NP = 4, CW = 6, MAXC = 31;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      moneda;
    logic [NP-1:0]   comprar;
    logic            cancelar;
    logic [NP*CW-1:0] precios;
    logic            cambio_ready;
    logic [NP-1:0]   listo, vend;
    logic [CW-1:0]   total;
    logic            cambio_valid;
    logic [1:0]      cambio_coin;
    logic            coin_reject;
`ifdef SALES_COUNT_EN
    logic [15:0]     ventas;
`endif

    always #5 clk = ~clk;

    vending_ctrl_multi #(.NUM_PROD(NP), .CREDIT_W(CW), .MAX_CREDIT(MAXC)) dut (
        .clk(clk), .reset(reset), .moneda(moneda), .comprar(comprar), .cancelar(cancelar),
        .precios(precios), .cambio_ready(cambio_ready), .listo(listo), .vend(vend),
        .total(total), .cambio_valid(cambio_valid), .cambio_coin(cambio_coin),
        .coin_reject(coin_reject)
`ifdef SALES_COUNT_EN
        , .ventas(ventas)
`endif
    );

    typedef struct { int total; int listo; bit cv; bit rej; } snap_t;
    typedef struct { int prod; int at; } vend_t;

    snap_t exp_cyc[$];
    vend_t exp_vend[$];
    int    exp_coin[$];

    int n_vec = 0, n_err = 0, cyc = 0;
    bit mon_en = 1'b0;

    int m_credit = 0;
    bit m_vending = 1'b0;
    bit m_rej = 1'b0;
    int m_pend[$];
    int price[NP];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic missing(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s cyc=%0d actual=output-present expected=no-pending-entry", name, cyc);
    endtask

    function automatic int model_listo();
        int m = 0;
        if (!m_vending && m_pend.size() == 0)
            for (int i = 0; i < NP; i++)
                if (price[i] != 0 && m_credit >= price[i]) m |= (1 << i);
        return m;
    endfunction

    function automatic int coin_code(input int v);
        return (v == 5) ? 3 : (v == 2) ? 2 : (v == 1) ? 1 : 0;
    endfunction

    // Refund list: as many fives as fit, then twos, then ones.
    task automatic greedy_fill();
        int c = m_credit;
        for (int k = 0; k < c / 5; k++) begin m_pend.push_back(5); exp_coin.push_back(5); end
        c = c % 5;
        for (int k = 0; k < c / 2; k++) begin m_pend.push_back(2); exp_coin.push_back(2); end
        if (c % 2 == 1) begin m_pend.push_back(1); exp_coin.push_back(1); end
    endtask

    task automatic set_prices(input int p0, input int p1, input int p2, input int p3);
        price[0] = p0; price[1] = p1; price[2] = p2; price[3] = p3;
        for (int i = 0; i < NP; i++) precios[i*CW +: CW] = price[i][CW-1:0];
    endtask

    task automatic step(input logic [1:0] mo, input logic [NP-1:0] co, input logic ca, input logic rdy);
        snap_t s;
        int v, sel;
        s.total = m_credit; s.listo = model_listo(); s.cv = (m_pend.size() != 0); s.rej = m_rej;
        exp_cyc.push_back(s);
        moneda = mo; comprar = co; cancelar = ca; cambio_ready = rdy;
        m_rej = 1'b0;
        v = (mo == 2'b01) ? 1 : (mo == 2'b10) ? 2 : (mo == 2'b11) ? 5 : 0;
        sel = -1;
        for (int i = NP - 1; i >= 0; i--) if (co[i]) sel = i;
        if (m_vending) begin
            m_vending = 1'b0;
            greedy_fill();
            m_rej = (v != 0);
        end else if (m_pend.size() != 0) begin
            m_rej = (v != 0);
            if (rdy) begin m_credit -= m_pend[0]; void'(m_pend.pop_front()); end
        end else if (ca && m_credit > 0) begin
            greedy_fill();
            m_rej = (v != 0);
        end else if (sel >= 0 && price[sel] != 0 && m_credit >= price[sel]) begin
            m_credit -= price[sel];
            m_vending = 1'b1;
            exp_vend.push_back('{sel, cyc + 1});
            m_rej = (v != 0);
        end else if (v != 0) begin
            if (m_credit + v <= MAXC) m_credit += v;
            else m_rej = 1'b1;
        end
        mon_en = 1'b1;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic coin(input logic [1:0] c);
        step(c, '0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((m_vending || m_pend.size() != 0) && n < 100) begin
            step(2'b00, '0, 1'b0, 1'b1);
            n++;
        end
        if (n >= 100) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout cyc=%0d actual=busy expected=idle", cyc);
        end
        step(2'b00, '0, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        snap_t e;
        vend_t ev;
        if (mon_en) begin
            if (exp_cyc.size() == 0) missing("snapshot");
            else begin
                e = exp_cyc.pop_front();
                check("total", total, e.total);
                check("listo", listo, e.listo);
                check("cambio_valid", cambio_valid, e.cv);
                check("coin_reject", coin_reject, e.rej);
                if (!cambio_valid) check("cambio_coin_idle", cambio_coin, 0);
            end
            if (vend != '0) begin
                if (exp_vend.size() == 0) missing("vend_unexpected");
                else begin
                    ev = exp_vend.pop_front();
                    check("vend", vend, 1 << ev.prod);
                    check("vend_cycle", cyc, ev.at);
                end
            end
            if (cambio_valid && cambio_ready) begin
                if (exp_coin.size() == 0) missing("change_unexpected");
                else check("cambio_coin", cambio_coin, coin_code(exp_coin.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b0; moneda = 2'b00; comprar = '0; cancelar = 1'b0; cambio_ready = 1'b0;
        set_prices(3, 7, 9, 12);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        coin(2'b11); coin(2'b10); coin(2'b10);
        step(2'b00, 4'b0100, 1'b0, 1'b1);
        coin(2'b00); coin(2'b00);

        coin(2'b11); coin(2'b11); coin(2'b10);
        step(2'b00, 4'b0001, 1'b0, 1'b1);
        step(2'b00, '0, 1'b0, 1'b1);
        step(2'b00, '0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(2'b01, '0, 1'b0, 1'b0);
        drain();

        for (int k = 0; k < 5; k++) coin(2'b11);
        coin(2'b10); coin(2'b10); coin(2'b11); coin(2'b10);
        step(2'b00, '0, 1'b1, 1'b1);
        drain();

        coin(2'b11); coin(2'b10); coin(2'b01);
        step(2'b11, '0, 1'b1, 1'b1);
        drain();

        for (int k = 0; k < 3000; k++) begin
            if (!m_vending && m_pend.size() == 0 && $urandom_range(0, 49) == 0)
                set_prices($urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 15));
            step($urandom_range(0, 1) ? 2'($urandom_range(1, 3)) : 2'b00,
                 ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        drain();
        check("vend_queue_empty", exp_vend.size(), 0);
        check("coin_queue_empty", exp_coin.size(), 0);

        set_prices(3, 7, 9, 12);
        coin(2'b10); coin(2'b10);
        step(2'b00, 4'b0011, 1'b0, 1'b0);
        step(2'b00, '0, 1'b0, 1'b0);
        step(2'b00, '0, 1'b0, 1'b0);
        mon_en = 1'b0;
        check("pre_reset_valid", cambio_valid, (m_pend.size() != 0) ? 1 : 0);
        #2 reset = 1'b0;
        #1;
        check("rst_total", total, 0);
        check("rst_vend", vend, 0);
        check("rst_cambio_valid", cambio_valid, 0);
        check("rst_cambio_coin", cambio_coin, 0);
        check("rst_coin_reject", coin_reject, 0);
        check("rst_listo", listo, 0);
        m_credit = 0; m_vending = 1'b0; m_rej = 1'b0;
        m_pend.delete(); exp_coin.delete(); exp_vend.delete(); exp_cyc.delete();
        @(posedge clk); #1 reset = 1'b1;
        coin(2'b01); coin(2'b00); coin(2'b00);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vending_ctrl_multi.md
Name: vending_ctrl_multi

Overview:
- Parametrised successor to the two-product coin vending controller.
- Supports NUM_PROD products with run-time prices and 1/2/5 coin credit accumulation with overflow rejection.
- Adds a cancel/refund path and greedy one-coin-per-cycle change dispensing with a ready handshake.
- Single FSM owns credit; sits between coin acceptor/keypad and the dispense/change actuators.

Parameters:
- NUM_PROD, 4, number of products (1..16).
- CREDIT_W, 6, width of credit and price values.
- MAX_CREDIT, 31, highest credit accepted; must be < 2**CREDIT_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- moneda  input  2  coin event, one cycle per coin: 00 none, 01 =1, 10 =2, 11 =5.
- comprar  input  NUM_PROD  purchase request, one bit per product, pulse.
- cancelar  input  1  refund request, pulse.
- precios  input  NUM_PROD*CREDIT_W  packed prices, product i at [i*CREDIT_W +: CREDIT_W]; stable while not IDLE.
- cambio_ready  input  1  change actuator accepts the presented coin.
- listo  output  NUM_PROD  bit i = state IDLE && total >= price i && price i != 0.
- vend  output  NUM_PROD  one-cycle one-hot dispense pulse.
- total  output  CREDIT_W  current credit.
- cambio_valid  output  1  change coin presented.
- cambio_coin  output  2  coin code presented (01/10/11), 00 when not valid.
- coin_reject  output  1  one-cycle pulse: inserted coin returned, not credited.

Behaviour:
- Reset (reset low, async): state IDLE, total=0, vend=0, cambio_valid=0, cambio_coin=00, coin_reject=0; listo all 0.
- States: IDLE, VEND, CHANGE. All outputs registered (Moore) except listo, which is combinational from state/total/precios.
- IDLE, priority cancelar > comprar > moneda, evaluated each cycle:
  - cancelar with total>0 -> CHANGE. cancelar with total=0 is ignored.
  - comprar: select the lowest set index i. If listo[i]: next cycle state VEND, vend[i]=1, total <= total - price i. If not listo[i]: request ignored, no state change.
  - moneda != 00: if total + value <= MAX_CREDIT, total updates on the next edge (1-cycle latency). Otherwise the coin is rejected: coin_reject=1 next cycle, total unchanged.
  - Any coin arriving in the same cycle as an accepted cancel or comprar is rejected (coin_reject pulse).
- VEND lasts exactly 1 cycle. Next state is CHANGE if total>0, else IDLE.
- CHANGE:
  - cambio_valid=1; cambio_coin is the largest coin <= total (5, then 2, then 1).
  - On cambio_valid && cambio_ready: total decreases by the coin value and the next coin is presented the following cycle.
  - When total reaches 0: cambio_valid drops and state returns to IDLE.
  - Holding cambio_ready high gives one coin per cycle. Holding it low holds the coin and total stable.
- Coins in VEND or CHANGE are always rejected. comprar and cancelar in VEND or CHANGE are ignored.
- Arithmetic: unsigned, CREDIT_W bits. Overflow is checked in CREDIT_W+1 bits, so no wrap-around. Subtraction never underflows (guarded by listo / greedy selection).
- Reset asserted mid-CHANGE or mid-VEND aborts immediately: credit is lost and outputs return to reset values.

Optional Feature:
- Macro SALES_COUNT_EN.
- Defined: adds output ventas[15:0], reset 0. Increments by 1 on every vend pulse, saturates at 16'hFFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then coins 5,2,2 on separate cycles -> total 5, 7, 9, each one cycle after its coin; coin_reject stays 0.
- Prices {3,7,9,12}, total=9, comprar=4'b0100 -> vend=4'b0100 for 1 cycle, total=0, return to IDLE, no change.
- total=12, buy product 0 (price 3), cambio_ready high -> vend[0] pulse, then change coins 5, 2, 2 on consecutive cycles, total 9->4->2->0, then IDLE. Drop cambio_ready for 3 cycles mid-sequence -> coin and total held.
- total=29, insert 5 -> coin_reject pulse, total stays 29; insert 2 -> total 31.
- total=8, assert cancelar and moneda=11 in the same cycle -> coin rejected; refund coins 5, 2, 1.
- comprar=4'b0011 with total=4 -> product 0 vended (price 3), change 1. Assert reset low mid-change -> all outputs 0 asynchronously.
